// File: rtl/vp_pixel_serializer.sv
// vp_pixel_serializer: buffers 64-bit words of packed colour indices in a small
// FIFO and emits one index per pixel_tick, leftmost pixel first. A missing
// pixel is reported as an underflow pulse and never stalls the raster.
module vp_pixel_serializer #(
   parameter int PIXEL_BITS      = 4,
   parameter int PIXELS_PER_WORD = 16,
   parameter int FIFO_DEPTH      = 2
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic [PIXEL_BITS*PIXELS_PER_WORD-1:0] pixels,
   input  logic                                  enable,
   output logic                                  ready,
   input  logic                                  line_start,
   input  logic                                  pixel_tick,
   output logic [PIXEL_BITS-1:0]                 color,
   output logic                                  color_valid,
   output logic                                  underflow,
   output logic                                  overflow
);

   localparam int WORD_W = PIXEL_BITS * PIXELS_PER_WORD;
   localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W  = (PIXELS_PER_WORD > 1) ? $clog2(PIXELS_PER_WORD) : 1;
   localparam logic [PTR_W:0]   DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(PIXELS_PER_WORD - 1);

   typedef enum logic {S_EMPTY, S_ACTIVE} state_t;

   state_t            state, state_nxt;
   logic [WORD_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [PTR_W:0]    fifo_count;
   logic [WORD_W-1:0] shift;
   logic [CNT_W-1:0]  count;
   logic              fifo_empty, push, load, shift_out, empty_tick;

   // ready comes from registered occupancy only, so it never depends on this cycle's pop
   assign ready      = (fifo_count < DEPTH_C);
   assign fifo_empty = (fifo_count == '0);
   assign push       = enable & ready & ~line_start;

   // Shifter state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_EMPTY;
      else        state <= state_nxt;
   end

   // Next-state and per-cycle shifter actions; line_start overrides everything
   always_comb begin
      state_nxt  = state;
      load       = 1'b0;
      shift_out  = 1'b0;
      empty_tick = 1'b0;
      case (state)
         S_EMPTY: begin
            empty_tick = pixel_tick;
            if (!fifo_empty) begin
               load      = 1'b1;
               state_nxt = S_ACTIVE;
            end
         end
         S_ACTIVE: begin
            if (pixel_tick) begin
               shift_out = 1'b1;
               // Reload on the same edge as the last pixel keeps back-to-back words gapless
               if (count == LAST_C) begin
                  if (!fifo_empty) load      = 1'b1;
                  else             state_nxt = S_EMPTY;
               end
            end
         end
         default: state_nxt = S_EMPTY;
      endcase
      if (line_start) begin
         state_nxt  = S_EMPTY;
         load       = 1'b0;
         shift_out  = 1'b0;
         empty_tick = 1'b0;
      end
   end

   // FIFO storage; contents need no reset since occupancy gates every read
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= pixels;
   end

   // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else if (line_start) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (load) rd_ptr <= rd_ptr + 1'b1;
         fifo_count <= fifo_count + (PTR_W+1)'(push) - (PTR_W+1)'(load);
      end
   end

   // Shift register, pixel counter and registered colour output
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shift       <= '0;
         count       <= '0;
         color       <= '0;
         color_valid <= 1'b0;
      end else if (line_start) begin
         shift       <= '0;
         count       <= '0;
         color       <= '0;
         color_valid <= 1'b0;
      end else begin
         if (load) begin
            shift <= mem[rd_ptr];
            count <= '0;
         end else if (shift_out) begin
            shift <= shift << PIXEL_BITS;
            count <= count + 1'b1;
         end
         if (shift_out) begin
            color       <= shift[WORD_W-1 -: PIXEL_BITS];
            color_valid <= 1'b1;
         end else if (empty_tick) begin
            color       <= '0;
            color_valid <= 1'b0;
         end
      end
   end

   // Single-cycle error pulses
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         underflow <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         underflow <= empty_tick;
         overflow  <= enable & ~ready & ~line_start;
      end
   end

endmodule
